// File: rtl/pass_pkg.sv
// pass_pipe shared definitions.
// Default sizes and the occupancy-counter width helper.
package pass_pkg;

  localparam int PASS_WIDTH_DEFAULT = 8;
  localparam int PASS_DEPTH_DEFAULT = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pass_stage.sv
// One valid+data slice of the pass pipeline.
// Data only toggles when a valid beat is loaded.
module pass_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clock) begin
    if (clear) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pass_pipe.sv
// DEPTH-stage valid/ready delay pipeline with bubble
// collapsing, synchronous flush and occupancy count.
module pass_pipe
  import pass_pkg::*;
#(
  parameter int               WIDTH      = PASS_WIDTH_DEFAULT,
  parameter int               DEPTH      = PASS_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [WIDTH-1:0] data [DEPTH];
  logic             clear;
  logic             in_xfer;
  logic             out_xfer;

  assign clear = !reset_n || flush;

  // Walk from the output back so each ready sees the ones ahead.
  always_comb begin
    logic r;
    r     = out_ready;
    ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r        = r || !valid[k];
      ready[k] = r;
    end
  end

  assign in_ready  = ready[0] && !flush && reset_n;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      pass_stage #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clock    (clock),
        .clear    (clear),
        .load     (ready[k]),
        .in_valid (in_xfer),
        .in_data  (in_data),
        .valid    (valid[k]),
        .data     (data[k])
      );
    end else begin : g_body
      pass_stage #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clock    (clock),
        .clear    (clear),
        .load     (ready[k]),
        .in_valid (valid[k-1]),
        .in_data  (data[k-1]),
        .valid    (valid[k]),
        .data     (data[k])
      );
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pass_pipe.sv
// Self-checking bench for pass_pipe: vector table, directed
// sequences, random traffic vs a queue model, DEPTH=1 variant.
module tb_pass_pipe;
  import pass_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [2:0]   count;

  logic         r1;
  logic         iv1;
  logic         ir1;
  logic [0:0]   id1;
  logic         ov1;
  logic         ordy1;
  logic [0:0]   od1;
  logic         fl1;
  logic [0:0]   cnt1;

  pass_pipe #(.WIDTH(W), .DEPTH(D), .RESET_DATA(8'h00)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  pass_pipe #(.WIDTH(1), .DEPTH(1), .RESET_DATA(1'b0)) dut1 (
    .clock     (clock),
    .reset_n   (r1),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .in_data   (id1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .out_data  (od1),
    .flush     (fl1),
    .count     (cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: ordered queue of beats, each tagged with its stage.
  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } beat_t;

  beat_t q[$];

  task automatic model_step();
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      logic ix;
      logic ox;
      int   lim;
      ix = in_valid && (q.size() < D || out_ready);
      ox = q.size() > 0 && q[0].pos == D - 1 && out_ready;
      if (ox) void'(q.pop_front());
      lim = D;
      foreach (q[i]) begin
        if (q[i].pos + 1 < lim - 1) q[i].pos = q[i].pos + 1;
        else q[i].pos = lim - 1;
        lim = q[i].pos;
      end
      if (ix) q.push_back('{d: in_data, pos: 0});
    end
  endtask

  task automatic mcheck(input string t);
    logic eov;
    logic eir;
    eov = q.size() > 0 && q[0].pos == D - 1;
    eir = reset_n && !flush && (q.size() < D || out_ready);
    chk({t, " out_valid"}, 32'(out_valid), 32'(eov));
    chk({t, " in_ready"}, 32'(in_ready), 32'(eir));
    chk({t, " count"}, 32'(count), q.size());
    if (eov) chk({t, " out_data"}, 32'(out_data), 32'(q[0].d));
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic o, input logic f,
                       input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    flush     = f;
    reset_n   = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         o;
    logic         f;
    logic         ov;
    logic         dchk;
    logic [W-1:0] od;
    logic [2:0]   cnt;
    logic         ir;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int exp_b;
    int first;
    int got[$];
    logic pv;
    logic [0:0] pd;
    logic sv;

    // Latency: single 0xA5 beat.
    tbl.push_back('{1, 8'hA5, 1, 0, 0, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'hA5, 1, 1});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1});
    // Flush after three accepts.
    tbl.push_back('{1, 8'h21, 0, 0, 0, 0, 8'h00, 0, 1});
    tbl.push_back('{1, 8'h22, 0, 0, 0, 0, 8'h00, 1, 1});
    tbl.push_back('{1, 8'h23, 0, 0, 0, 0, 8'h00, 2, 1});
    tbl.push_back('{1, 8'h24, 0, 1, 0, 0, 8'h00, 3, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 1, 8'h00, 0, 1});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1});

    in_valid = 0; in_data = 0; out_ready = 1;
    flush = 0; reset_n = 0;
    r1 = 0; iv1 = 0; id1 = 0; ordy1 = 1; fl1 = 0;
    @(negedge clock);

    repeat (3) begin
      drive(0, 0, 1, 0, 0);
      chk("reset in_ready", 32'(in_ready), 0);
      tick();
    end
    drive(0, 0, 1, 0, 1);
    chk("idle out_valid", 32'(out_valid), 0);
    chk("idle out_data", 32'(out_data), 0);
    chk("idle count", 32'(count), 0);
    chk("idle in_ready", 32'(in_ready), 1);
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].f, 1'b1);
      chk($sformatf("vec%0d out_valid", i),
          32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d count", i),
          32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d in_ready", i),
          32'(in_ready), 32'(tbl[i].ir));
      if (tbl[i].dchk)
        chk($sformatf("vec%0d out_data", i),
            32'(out_data), 32'(tbl[i].od));
      tick();
    end

    // Streaming 16 beats back to back.
    first = -1;
    for (int c = 0; c < 30 && got.size() < 16; c++) begin
      sv = (c < 16);
      drive(sv, 8'(c), 1, 0, 1);
      if (sv) chk("stream in_ready", 32'(in_ready), 1);
      if (out_valid) begin
        if (first < 0) first = c;
        chk("stream cycle", c, first + got.size());
        chk("stream data", 32'(out_data), got.size());
        got.push_back(int'(out_data));
      end
      tick();
    end
    chk("stream beats", got.size(), 16);
    chk("stream first", first, 4);

    // Backpressure: fill, then drain in order.
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1, 8'(8'h10 + acc), 0, 0, 1);
      if (!in_ready) break;
      acc++;
      tick();
    end
    chk("bp accepts", acc, 4);
    chk("bp count", 32'(count), 4);
    chk("bp in_ready", 32'(in_ready), 0);
    exp_b = 8'h10;
    for (int c = 0; c < 10 && exp_b <= 8'h13; c++) begin
      drive(0, 0, 1, 0, 1);
      if (out_valid) begin
        chk("bp data", 32'(out_data), exp_b);
        exp_b++;
      end
      tick();
    end
    chk("bp drained", exp_b, 8'h14);
    drive(0, 0, 1, 0, 1);
    chk("bp empty count", 32'(count), 0);
    tick();

    // Reset with a full pipeline.
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(8'h30 + i), 0, 0, 1);
      tick();
    end
    drive(1, 8'h40, 0, 0, 1);
    chk("full count", 32'(count), 4);
    chk("full in_ready", 32'(in_ready), 0);
    tick();
    drive(1, 8'h41, 1, 0, 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    tick();
    drive(0, 0, 1, 0, 1);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst out_data", 32'(out_data), 0);
    chk("midrst count", 32'(count), 0);
    chk("midrst in_ready", 32'(in_ready), 1);
    tick();
    repeat (5) begin
      drive(0, 0, 1, 0, 1);
      chk("midrst no beat", 32'(out_valid), 0);
      tick();
    end

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0,
            !($urandom_range(0, 99) == 0));
      mcheck("rand");
      tick();
    end

    // DEPTH=1, WIDTH=1 single-register behaviour.
    r1 = 0; iv1 = 1; id1 = 1;
    repeat (2) begin
      drive(0, 0, 1, 0, 1);
      chk("d1 rst in_ready", 32'(ir1), 0);
      tick();
    end
    r1 = 1; iv1 = 0; id1 = 0;
    drive(0, 0, 1, 0, 1);
    chk("d1 rst out_valid", 32'(ov1), 0);
    chk("d1 rst out_data", 32'(od1), 0);
    chk("d1 rst count", 32'(cnt1), 0);
    pv = 0; pd = 0;
    for (int i = 0; i < 12; i++) begin
      iv1 = 1'($urandom_range(0, 1));
      id1 = 1'($urandom_range(0, 1));
      ordy1 = 1;
      drive(0, 0, 1, 0, 1);
      chk("d1 out_valid", 32'(ov1), 32'(pv));
      chk("d1 count", 32'(cnt1), 32'(pv));
      chk("d1 in_ready", 32'(ir1), 1);
      if (pv) chk("d1 out_data", 32'(od1), 32'(pd));
      pv = iv1;
      if (iv1) pd = id1;
      tick();
    end
    iv1 = 1; id1 = 1; ordy1 = 1;
    drive(0, 0, 1, 0, 1);
    tick();
    iv1 = 1; id1 = 0; ordy1 = 0;
    drive(0, 0, 1, 0, 1);
    chk("d1 full out_valid", 32'(ov1), 1);
    chk("d1 full out_data", 32'(od1), 1);
    chk("d1 full in_ready", 32'(ir1), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
